// File: rtl/pwm_ramp_ctrl.sv
// Multi-channel PWM duty controller: accepts duty commands over valid/ready and
// ramps or jumps each channel's duty, updating only on PWM frame boundaries.
module pwm_ramp_ctrl #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned CH_BITS  = 2,
   parameter int unsigned RAMP_DIV = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [CH_BITS-1:0]        cmd_channel,
   input  logic [WIDTH-1:0]          cmd_target,
   input  logic                      cmd_immediate,
   output logic [CHANNELS*WIDTH-1:0] value_bus,
   output logic [CHANNELS-1:0]       busy,
   output logic                      frame_start
);

   localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
   localparam logic [WIDTH-1:0] FRAME_PRE_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

   typedef struct packed {
      logic [CH_BITS-1:0] ch;
      logic [WIDTH-1:0]   tgt;
      logic               imm;
   } cmd_t;

   logic [WIDTH-1:0]    frame_cnt;
   logic [PRE_W-1:0]    pre_cnt;
   logic                pend_valid;
   logic                pend_valid_n;
   cmd_t                pend;
   logic                step;
   logic                transfer;
   logic [WIDTH-1:0]    cur   [CHANNELS];
   logic [WIDTH-1:0]    tgt   [CHANNELS];
   logic [WIDTH-1:0]    cur_n [CHANNELS];
   logic [WIDTH-1:0]    tgt_n [CHANNELS];
   logic [CHANNELS-1:0] busy_n;

   // frame_start is registered one cycle early so it is high while the counter is at its last value
   assign step     = frame_start && (pre_cnt == PRE_LAST);
   assign transfer = cmd_valid && cmd_ready;

   // A transfer on a boundary edge wins: the old (empty) pending slot is what gets applied
   always_comb begin
      pend_valid_n = pend_valid;
      if (transfer) begin
         pend_valid_n = 1'b1;
      end else if (frame_start) begin
         pend_valid_n = 1'b0;
      end
   end

   // Per-channel next duty: a command on this boundary overrides the ramp step for its channel
   always_comb begin
      busy_n = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         cur_n[i] = cur[i];
         tgt_n[i] = tgt[i];
         if (frame_start && pend_valid && (pend.ch == CH_BITS'(i))) begin
            tgt_n[i] = pend.tgt;
            if (pend.imm) begin
               cur_n[i] = pend.tgt;
            end
         end else if (step) begin
            if (cur[i] < tgt[i]) begin
               cur_n[i] = cur[i] + WIDTH'(1);
            end else if (cur[i] > tgt[i]) begin
               cur_n[i] = cur[i] - WIDTH'(1);
            end
         end
         busy_n[i] = (cur_n[i] != tgt_n[i]);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_cnt   <= '0;
         frame_start <= 1'b0;
         pre_cnt     <= '0;
         pend_valid  <= 1'b0;
         pend        <= '0;
         cmd_ready   <= 1'b0;
         busy        <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cur[i] <= '0;
            tgt[i] <= '0;
         end
      end else begin
         frame_cnt   <= frame_cnt + WIDTH'(1);
         frame_start <= (frame_cnt == FRAME_PRE_LAST);
         if (frame_start) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
         end
         pend_valid <= pend_valid_n;
         cmd_ready  <= !pend_valid_n;
         if (transfer) begin
            pend.ch  <= cmd_channel;
            pend.tgt <= cmd_target;
            pend.imm <= cmd_immediate;
         end
         cur  <= cur_n;
         tgt  <= tgt_n;
         busy <= busy_n;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
      assign value_bus[g*WIDTH +: WIDTH] = cur[g];
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: timeline table for ramp/retarget scenarios plus
// hand sequences for back-to-back handshake, reset mid-ramp and out-of-range channel.
module tb_pwm_ramp_ctrl;

   logic        clock;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_channel;
   logic [3:0]  cmd_target;
   logic        cmd_immediate;
   logic [15:0] value_bus;
   logic [3:0]  busy;
   logic        frame_start;

   logic        c3_valid;
   logic        c3_ready;
   logic [1:0]  c3_channel;
   logic [3:0]  c3_target;
   logic        c3_imm;
   logic [11:0] c3_value;
   logic [2:0]  c3_busy;
   logic        c3_frame;

   pwm_ramp_ctrl #(.WIDTH(4), .CHANNELS(4), .CH_BITS(2), .RAMP_DIV(2)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_channel(cmd_channel), .cmd_target(cmd_target), .cmd_immediate(cmd_immediate),
      .value_bus(value_bus), .busy(busy), .frame_start(frame_start)
   );

   pwm_ramp_ctrl #(.WIDTH(4), .CHANNELS(3), .CH_BITS(2), .RAMP_DIV(2)) dut3 (
      .clock(clock), .reset(reset),
      .cmd_valid(c3_valid), .cmd_ready(c3_ready),
      .cmd_channel(c3_channel), .cmd_target(c3_target), .cmd_immediate(c3_imm),
      .value_bus(c3_value), .busy(c3_busy), .frame_start(c3_frame)
   );

   typedef struct {
      int unsigned at;
      bit          is_send;
      logic [1:0]  ch;
      logic [3:0]  tgt;
      logic        imm;
      logic [15:0] value;
      logic [3:0]  busy;
      logic        ready;
   } vec_t;

   vec_t        tbl[$];
   int          checks;
   int          errors;
   int unsigned cyc;
   bit          chk_fs;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock; frame_start must be high exactly when the frame counter sits at 15
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (chk_fs) begin
         check("frame_start", 32'(frame_start), 32'(cyc % 16 == 15));
         check("frame_start3", 32'(c3_frame), 32'(cyc % 16 == 15));
      end
   endtask

   task automatic go_to(input int unsigned n);
      if (cyc > n) begin
         errors++;
         $display("FAIL schedule: at cyc %0d, expected at most %0d", cyc, n);
      end
      while (cyc < n) tick();
   endtask

   task automatic chk(input string tag, input logic [15:0] v, input logic [3:0] b, input logic r);
      check({tag, "_value"}, 32'(value_bus), 32'(v));
      check({tag, "_busy"}, 32'(busy), 32'(b));
      check({tag, "_ready"}, 32'(cmd_ready), 32'(r));
   endtask

   task automatic send(input logic [1:0] ch, input logic [3:0] tgt, input logic imm);
      cmd_channel   = ch;
      cmd_target    = tgt;
      cmd_immediate = imm;
      cmd_valid     = 1'b1;
      check("send_ready", 32'(cmd_ready), 32'(1));
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic send3(input logic [1:0] ch, input logic [3:0] tgt, input logic imm);
      c3_channel = ch;
      c3_target  = tgt;
      c3_imm     = imm;
      c3_valid   = 1'b1;
      check("send3_ready", 32'(c3_ready), 32'(1));
      tick();
      c3_valid = 1'b0;
   endtask

   function automatic void add_chk(input int unsigned at, input logic [15:0] v,
                                   input logic [3:0] b, input logic r);
      tbl.push_back('{at: at, is_send: 1'b0, ch: 2'd0, tgt: 4'd0, imm: 1'b0,
                      value: v, busy: b, ready: r});
   endfunction

   function automatic void add_send(input int unsigned at, input logic [1:0] ch,
                                    input logic [3:0] tgt, input logic imm);
      tbl.push_back('{at: at, is_send: 1'b1, ch: ch, tgt: tgt, imm: imm,
                      value: 16'h0, busy: 4'h0, ready: 1'b0});
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      chk_fs = 1'b0;
      reset  = 1'b1;
      cmd_valid = 1'b0; cmd_channel = '0; cmd_target = '0; cmd_immediate = 1'b0;
      c3_valid  = 1'b0; c3_channel  = '0; c3_target  = '0; c3_imm        = 1'b0;

      // Boundaries at every 16th edge after release; step boundaries at multiples of 32
      add_chk (1,   16'h0000, 4'b0000, 1'b1);
      add_send(3,   2'd1, 4'd5, 1'b1);
      add_chk (4,   16'h0000, 4'b0000, 1'b0);
      add_chk (15,  16'h0000, 4'b0000, 1'b0);
      add_chk (16,  16'h0050, 4'b0000, 1'b1);
      add_send(17,  2'd0, 4'd3, 1'b0);
      add_chk (18,  16'h0050, 4'b0000, 1'b0);
      add_chk (32,  16'h0050, 4'b0001, 1'b1);
      add_send(33,  2'd2, 4'd10, 1'b0);
      add_chk (48,  16'h0050, 4'b0101, 1'b1);
      add_send(49,  2'd3, 4'd6, 1'b0);
      add_chk (64,  16'h0151, 4'b1101, 1'b1);
      add_chk (96,  16'h1252, 4'b1101, 1'b1);
      add_chk (128, 16'h2353, 4'b1100, 1'b1);
      add_chk (160, 16'h3453, 4'b1100, 1'b1);
      add_chk (176, 16'h3453, 4'b1100, 1'b1);
      add_send(177, 2'd2, 4'd2, 1'b0);
      add_chk (192, 16'h4453, 4'b1100, 1'b1);
      add_chk (224, 16'h5353, 4'b1100, 1'b1);
      add_chk (256, 16'h6253, 4'b0000, 1'b1);
      add_chk (288, 16'h6253, 4'b0000, 1'b1);

      repeat (3) tick();
      chk("in_reset", 16'h0000, 4'b0000, 1'b0);
      check("in_reset_frame", 32'(frame_start), 32'(0));
      check("in_reset_ready3", 32'(c3_ready), 32'(0));

      reset  = 1'b0;
      cyc    = 0;
      chk_fs = 1'b1;

      foreach (tbl[k]) begin
         go_to(tbl[k].at);
         if (tbl[k].is_send) send(tbl[k].ch, tbl[k].tgt, tbl[k].imm);
         else chk($sformatf("t%0d", tbl[k].at), tbl[k].value, tbl[k].busy, tbl[k].ready);
      end

      // Back-to-back with cmd_valid held: second transfer waits for the first apply
      go_to(289);
      cmd_channel = 2'd1; cmd_target = 4'd15; cmd_immediate = 1'b0; cmd_valid = 1'b1;
      check("b2b_ready_first", 32'(cmd_ready), 32'(1));
      tick();
      cmd_channel = 2'd0; cmd_target = 4'd0; cmd_immediate = 1'b1;
      chk("b2b290", 16'h6253, 4'b0000, 1'b0);
      go_to(303);
      chk("b2b303", 16'h6253, 4'b0000, 1'b0);
      go_to(304);
      chk("b2b304", 16'h6253, 4'b0010, 1'b1);
      tick();
      cmd_valid = 1'b0;
      chk("b2b305", 16'h6253, 4'b0010, 1'b0);
      go_to(320);
      chk("b2b320", 16'h6260, 4'b0010, 1'b1);
      go_to(576);
      chk("ramp576", 16'h62E0, 4'b0010, 1'b1);
      go_to(608);
      chk("ramp608", 16'h62F0, 4'b0000, 1'b1);
      go_to(640);
      chk("ramp640", 16'h62F0, 4'b0000, 1'b1);

      // Reset while ch0 is mid-ramp and a command is pending
      go_to(641);
      send(2'd0, 4'd9, 1'b0);
      go_to(656);
      chk("e656", 16'h62F0, 4'b0001, 1'b1);
      go_to(864);
      chk("e864", 16'h62F7, 4'b0001, 1'b1);
      go_to(865);
      send(2'd1, 4'd3, 1'b1);
      go_to(870);
      chk("e870", 16'h62F7, 4'b0001, 1'b0);
      chk_fs = 1'b0;
      reset  = 1'b1;
      #1;
      chk("rst_async", 16'h0000, 4'b0000, 1'b0);
      check("rst_async_frame", 32'(frame_start), 32'(0));
      repeat (2) tick();
      reset  = 1'b0;
      cyc    = 0;
      chk_fs = 1'b1;
      go_to(20);
      chk("post_rst20", 16'h0000, 4'b0000, 1'b1);

      // Out-of-range channel on a 3-channel instance is accepted and discarded
      go_to(21);
      send3(2'd0, 4'd6, 1'b1);
      check("d3_ready22", 32'(c3_ready), 32'(0));
      go_to(32);
      check("d3_value32", 32'(c3_value), 32'(12'h006));
      check("d3_busy32", 32'(c3_busy), 32'(0));
      check("d3_ready32", 32'(c3_ready), 32'(1));
      go_to(33);
      send3(2'd3, 4'd9, 1'b1);
      check("d3_ready34", 32'(c3_ready), 32'(0));
      go_to(48);
      check("d3_value48", 32'(c3_value), 32'(12'h006));
      check("d3_busy48", 32'(c3_busy), 32'(0));
      check("d3_ready48", 32'(c3_ready), 32'(1));
      chk("main48", 16'h0000, 4'b0000, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Multi-channel duty-cycle controller that feeds the `value` inputs of CHANNELS pwm instances. It accepts duty commands over a valid/ready handshake. Each channel's duty moves toward its target one LSB per ramp step (soft start/stop), or jumps immediately on request. All duty updates occur only at PWM frame boundaries, so no glitched periods reach the pwm outputs. A frame_start strobe is provided to align the pwm counters.

Parameters:
WIDTH, 4, duty/counter width; frame length = 2^WIDTH clocks (matches pwm WIDTH)
CHANNELS, 4, number of pwm channels driven
CH_BITS, 2, width of cmd_channel (>= clog2(CHANNELS))
RAMP_DIV, 16, frames per ramp step (>= 1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_channel  in  CH_BITS  target channel index
cmd_target  in  WIDTH  requested duty value
cmd_immediate  in  1  1 = jump to target, 0 = ramp to target
value_bus  out  CHANNELS*WIDTH  current duty; channel i at bits [i*WIDTH +: WIDTH]
busy  out  CHANNELS  busy[i]=1 while current[i] != target[i]
frame_start  out  1  high during last clock of each frame

Behaviour:
- Reset (async assert, released synchronously with clock): frame counter=0, ramp prescaler=0, all current[i]=0, all target[i]=0, pending register empty, value_bus=0, busy=0, frame_start=0, cmd_ready=0 while reset is high.
- Frame counter: WIDTH bits, increments every clock, wraps from 2^WIDTH-1 to 0. frame_start = (counter == 2^WIDTH-1), combinational from the counter. The clock edge at which frame_start=1 is the "boundary"; all current/target updates happen only on boundary edges.
- Ramp prescaler: counts boundaries 0..RAMP_DIV-1, then wraps. A boundary is a "step boundary" when the prescaler equals RAMP_DIV-1. With RAMP_DIV=1, every boundary is a step boundary.
- Handshake: cmd_ready = !pending_valid (and 0 in reset). Transfer occurs on a rising edge with cmd_valid && cmd_ready. {channel, target, immediate} is latched into a single-entry pending register. cmd_valid may drop without transfer; there is no combinational path from cmd_valid to cmd_ready.
- Command apply: at the first boundary edge strictly after the transfer edge, the pending command is applied and pending_valid is cleared. cmd_ready is 1 again on the next cycle. A transfer on a boundary edge applies at the following boundary, 2^WIDTH clocks later.
- Apply rules for channel ch:
  - target[ch] <= cmd_target.
  - If immediate, current[ch] <= cmd_target; otherwise current[ch] is unchanged on that edge.
  - If ch >= CHANNELS, the command is accepted and then discarded at the boundary, with no state change.
- Ramp step, at each step boundary, for every channel not being written by a command on the same edge:
  - current < target: current + 1.
  - current > target: current - 1.
  - Equal: hold.
  - No wrap: the value moves only toward the target, so it never passes 0 or 2^WIDTH-1.
- Simultaneous events: a command on the same edge as a step overrides the step for its channel only; other channels step normally.
- A retarget mid-ramp takes effect from the apply boundary; the ramp reverses direction if needed.
- value_bus and busy are registered (busy is derived from registered state). They change only on boundary edges.
- Reset mid-ramp or mid-handshake: everything returns to reset values at once; any pending command is lost.

Test Plan:
- Reset release, WIDTH=4, RAMP_DIV=2 -> value_bus=0, busy=0, cmd_ready=1 after first clock; frame_start pulses every 16 clocks at counter=15.
- Command ch1 target=5, immediate=1, accepted mid-frame -> at next boundary value_bus[7:4]=5; busy[1] never asserts; cmd_ready is 0 from transfer until one clock after that boundary.
- Command ch0 target=3, ramp -> ch0 reads 1, 2, 3 at successive step boundaries (every 32 clocks); busy[0]=1 until it reaches 3, then 0; value stays 3 thereafter.
- Ch2 ramping 0→10, at value 4 retarget to 2 (ramp) -> 4 held on the apply boundary, then 3, 2 at next step boundaries; ch3 ramping concurrently continues unaffected.
- Back-to-back commands with cmd_valid held -> second transfer only after the first applies; command with channel=3 when CHANNELS=3 is accepted and produces no change; cmd_target=15 ramp from 0 ends at 15 with no wrap.
- Assert reset at ch0=7 mid-ramp with a pending command -> value_bus=0, busy=0, cmd_ready=0 immediately; after release the pending command is not applied.
